fetch_ctrl: RTL and testbench

//  Sequencing controller for the IF stage.
//  - Owns the PC and drives the address of the synchronous (1-cycle latency) instruction ROM.
//  - Realigns the ROM read data with its PC and tags each instruction with a valid bit.
//  - Holds the IF/ID output under decode stall (skid register) and kills in-flight fetches on a MEM-stage redirect.
//  - Sits between the ROM instance and the IF/ID pipeline register.

---
 rtl/fetch_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl - instruction-fetch (IF) sequencing controller
//
// Sits between a synchronous instruction ROM with a 1-cycle read latency and
// the IF/ID pipeline register. Its jobs are:
//   * own the fetch PC and drive the ROM address from it
//   * line up the ROM read data with the PC that produced it
//   * hold the IF/ID output steady while decode stalls (skid register)
//   * kill in-flight fetches when the MEM stage redirects the PC
//
// Ports
//   clk               in   1       clock; all state updates on posedge
//   rst               in   1       synchronous active-high reset
//   stall_id_if       in   1       decode cannot accept this cycle
//   branch_mem_if     in   1       redirect request from the MEM stage
//   PC_branch_mem_if  in   32      redirect target (low two bits ignored)
//   rom_addr          out  ADDR_W  ROM byte address (combinational from fetch PC)
//   rom_r_data        in   32      ROM data for the address of the previous cycle
//   instr_if_id       out  32      instruction to IF/ID
//   PC_if_id          out  32      PC of instr_if_id
//   valid_if_id       out  1       instr_if_id/PC_if_id carry a real instruction
//   bubble_cnt        out  32      saturating count of invalid cycles since reset
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_id_if,
    input  logic              branch_mem_if,
    input  logic [31:0]       PC_branch_mem_if,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_r_data,
    output logic [31:0]       instr_if_id,
    output logic [31:0]       PC_if_id,
    output logic              valid_if_id,
    output logic [31:0]       bubble_cnt
);

    // REFILL: the ROM is being primed after reset or a redirect, output is a
    //         bubble. RUN: streaming one instruction per cycle. HOLD: decode
    //         is stalled and the output comes from the skid register.
    typedef enum logic [1:0] {
        ST_REFILL = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    state_e      state_q,      state_d;
    logic [31:0] fetch_pc_q,   fetch_pc_d;
    logic [31:0] resp_pc_q,    resp_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q,    skid_pc_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] fetch_pc_inc_s;

    // PC+4 wraps modulo 2^32 by construction of the 32-bit add.
    assign fetch_pc_inc_s = fetch_pc_q + 32'd4;
    assign rom_addr       = fetch_pc_q[ADDR_W-1:0];
    assign bubble_cnt     = bubble_cnt_q;

    // Output mux: skid contents while holding, otherwise the ROM response
    // tagged with the PC it was fetched for. Reset forces a clean bubble even
    // before the first reset edge has been seen.
    always_comb begin
        instr_if_id = NOP_INSTR;
        PC_if_id    = resp_pc_q;
        valid_if_id = 1'b0;
        if (rst) begin
            instr_if_id = NOP_INSTR;
            PC_if_id    = 32'h0000_0000;
            valid_if_id = 1'b0;
        end else if (state_q == ST_HOLD) begin
            instr_if_id = skid_instr_q;
            PC_if_id    = skid_pc_q;
            valid_if_id = 1'b1;
        end else if (resp_valid_q) begin
            instr_if_id = rom_r_data;
            PC_if_id    = resp_pc_q;
            valid_if_id = 1'b1;
        end else begin
            instr_if_id = NOP_INSTR;
            PC_if_id    = resp_pc_q;
            valid_if_id = 1'b0;
        end
    end

    // Next-state logic for the sequencing FSM and its datapath registers.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (branch_mem_if) begin
            // Redirect beats stall: whatever is in flight or held is dropped.
            fetch_pc_d   = PC_branch_mem_if & ~32'h0000_0003;
            resp_valid_d = 1'b0;
            skid_instr_d = 32'h0000_0000;
            skid_pc_d    = 32'h0000_0000;
            state_d      = ST_REFILL;
        end else begin
            case (state_q)
                ST_REFILL: begin
                    // Stall is ignored here: the output is a bubble anyway.
                    fetch_pc_d   = fetch_pc_inc_s;
                    resp_pc_d    = fetch_pc_q;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RUN;
                end
                ST_RUN: begin
                    if (stall_id_if) begin
                        // Park the instruction decode refused; the ROM keeps
                        // reading fetch_pc so its data is ready on release.
                        skid_instr_d = rom_r_data;
                        skid_pc_d    = resp_pc_q;
                        resp_pc_d    = fetch_pc_q;
                        state_d      = ST_HOLD;
                    end else begin
                        fetch_pc_d   = fetch_pc_inc_s;
                        resp_pc_d    = fetch_pc_q;
                        resp_valid_d = 1'b1;
                        state_d      = ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (stall_id_if) begin
                        state_d = ST_HOLD;
                    end else begin
                        // Skid is consumed this cycle; the ROM already holds
                        // data for fetch_pc, so the next cycle has no gap.
                        fetch_pc_d   = fetch_pc_inc_s;
                        resp_pc_d    = fetch_pc_q;
                        resp_valid_d = 1'b1;
                        state_d      = ST_RUN;
                    end
                end
                default: begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_REFILL;
                end
            endcase
        end
    end

    // Bubble counter increments on every invalid cycle and saturates.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!valid_if_id && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_REFILL;
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            skid_instr_q <= 32'h0000_0000;
            skid_pc_q    <= 32'h0000_0000;
            bubble_cnt_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl - directed, table-driven bench for fetch_ctrl.
// A behavioural ROM returns a distinct word per byte address one cycle after
// the address is presented. Each table row gives the inputs for one cycle and
// the outputs expected during that cycle.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_id_if;
    logic        branch_mem_if;
    logic [31:0] PC_branch_mem_if;
    logic [15:0] rom_addr;
    logic [31:0] rom_r_data;
    logic [31:0] instr_if_id;
    logic [31:0] PC_if_id;
    logic        valid_if_id;
    logic [31:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .stall_id_if      (stall_id_if),
        .branch_mem_if    (branch_mem_if),
        .PC_branch_mem_if (PC_branch_mem_if),
        .rom_addr         (rom_addr),
        .rom_r_data       (rom_r_data),
        .instr_if_id      (instr_if_id),
        .PC_if_id         (PC_if_id),
        .valid_if_id      (valid_if_id),
        .bubble_cnt       (bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [15:0] a);
        return {16'hA5C3 ^ a, a};
    endfunction

    // Synchronous ROM model with one cycle of read latency.
    always_ff @(posedge clk) begin
        rom_r_data <= rom_fn(rom_addr);
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc;
        logic        chk_pc;
        logic [31:0] ebub;
        logic        chk_bub;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic r, input logic s, input logic b,
                                input logic [31:0] t, input logic ev,
                                input logic [31:0] epc, input logic cpc,
                                input logic [31:0] ebub, input logic cbub);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.ev = ev;
        v.epc = epc; v.chk_pc = cpc; v.ebub = ebub; v.chk_bub = cbub;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b,
                         input logic [31:0] t);
        @(negedge clk);
        rst = r; stall_id_if = s; branch_mem_if = b; PC_branch_mem_if = t;
        #1;
    endtask

    // Check outputs of the current cycle against a valid flag and PC.
    task automatic check_out(input string tag, input logic ev,
                             input logic [31:0] epc, input logic cpc);
        logic [31:0] exp_instr;
        exp_instr = ev ? rom_fn(epc[15:0]) : NOP;
        check32({tag, ".valid"}, {31'd0, valid_if_id}, {31'd0, ev});
        check32({tag, ".instr"}, instr_if_id, exp_instr);
        if (cpc) check32({tag, ".pc"}, PC_if_id, epc);
    endtask

    initial begin
        rst = 1'b1; stall_id_if = 1'b0; branch_mem_if = 1'b0;
        PC_branch_mem_if = 32'h0;

        // rst stall br tgt           ev  pc           chkpc bub  chkbub
        vecs[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'd0, 0);
        vecs[1]  = mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'd0, 1);
        // reset release, streaming
        vecs[2]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'd0, 1);
        vecs[3]  = mk(0, 0, 0, 32'h0,        1, 32'h0,        1, 32'd1, 1);
        vecs[4]  = mk(0, 0, 0, 32'h0,        1, 32'h4,        1, 32'd1, 1);
        // stall for three cycles at PC 8
        vecs[5]  = mk(0, 1, 0, 32'h0,        1, 32'h8,        1, 32'd1, 1);
        vecs[6]  = mk(0, 1, 0, 32'h0,        1, 32'h8,        1, 32'd1, 1);
        vecs[7]  = mk(0, 1, 0, 32'h0,        1, 32'h8,        1, 32'd1, 1);
        vecs[8]  = mk(0, 0, 0, 32'h0,        1, 32'h8,        1, 32'd1, 1);
        // redirect to 0x40 while PC 12 is out
        vecs[9]  = mk(0, 0, 1, 32'h40,       1, 32'hC,        1, 32'd1, 1);
        vecs[10] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'd1, 1);
        vecs[11] = mk(0, 0, 0, 32'h0,        1, 32'h40,       1, 32'd2, 1);
        vecs[12] = mk(0, 1, 0, 32'h0,        1, 32'h44,       1, 32'd2, 1);
        // branch + stall together during HOLD
        vecs[13] = mk(0, 1, 1, 32'h80,       1, 32'h44,       1, 32'd2, 1);
        vecs[14] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'd2, 1);
        vecs[15] = mk(0, 0, 0, 32'h0,        1, 32'h80,       1, 32'd3, 1);
        // misaligned target
        vecs[16] = mk(0, 0, 1, 32'h43,       1, 32'h84,       1, 32'd3, 1);
        vecs[17] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'd3, 1);
        vecs[18] = mk(0, 0, 0, 32'h0,        1, 32'h40,       1, 32'd4, 1);
        // wrap from the top of the address space
        vecs[19] = mk(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h44,      1, 32'd4, 1);
        vecs[20] = mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'd4, 1);
        vecs[21] = mk(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 32'd5, 1);
        vecs[22] = mk(0, 0, 0, 32'h0,        1, 32'h0,        1, 32'd5, 1);
        // enter HOLD for the reset-mid-hold sequence below
        vecs[23] = mk(0, 1, 0, 32'h0,        1, 32'h4,        1, 32'd5, 1);
        vecs[24] = mk(0, 1, 0, 32'h0,        1, 32'h4,        1, 32'd5, 1);

        for (int i = 0; i < 25; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt);
            check_out(tag, vecs[i].ev, vecs[i].epc, vecs[i].chk_pc);
            if (vecs[i].chk_bub) check32({tag, ".bubble"}, bubble_cnt, vecs[i].ebub);
        end

        // Redirect bubble cycle must address the aligned target.
        // (covered by table; here: reset asserted while holding PC 4)
        drive(1, 1, 0, 32'h0);
        check_out("rst_hold", 1'b0, 32'h0, 1'b1);

        // First cycle after reset: bubble, ROM at RESET_PC, counter cleared;
        // stall is ignored while refilling.
        drive(0, 1, 0, 32'h0);
        check_out("post_rst", 1'b0, 32'h0, 1'b1);
        check32("post_rst.rom_addr", {16'd0, rom_addr}, 32'h0);
        check32("post_rst.bubble", bubble_cnt, 32'd0);

        drive(0, 0, 0, 32'h0);
        check_out("restart0", 1'b1, 32'h0, 1'b1);
        check32("restart0.bubble", bubble_cnt, 32'd1);
        drive(0, 0, 0, 32'h0);
        check_out("restart1", 1'b1, 32'h4, 1'b1);
        drive(0, 0, 0, 32'h0);
        check_out("restart2", 1'b1, 32'h8, 1'b1);
        check32("restart2.rom_addr", {16'd0, rom_addr}, 32'hC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
